// File: rtl/gray_angle_bcd_seq.sv
// Absolute rotary encoder front end: sync + debounce a Gray position, convert to binary,
// degrees and 3 BCD digits. Optional direction/turn tracking with `define GRAY_DIR_EN.
module gray_angle_bcd_seq #(
  parameter int unsigned POS_W      = 3,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [POS_W-1:0]        gray_in,
  output logic [POS_W-1:0]        pos_bin,
  output logic [8:0]              degrees,
  output logic [3:0]              bcd_hund,
  output logic [3:0]              bcd_tens,
  output logic [3:0]              bcd_ones,
  output logic                    valid,
  output logic                    busy
`ifdef GRAY_DIR_EN
  ,
  output logic                    dir,
  output logic                    step_err,
  output logic signed [7:0]       turns
`endif
);

  localparam int unsigned ProdW = POS_W + 9;

  typedef enum logic [1:0] {StIdle, StLoad, StConv, StDone} state_e;

  state_e state_q, state_d;

  logic [POS_W-1:0] sync1_q, sync2_q, cand_q, acc_q;
  logic [7:0]       cnt_q;
  logic             pending_q;
  logic             accept;

  logic [POS_W-1:0] acc_bin;
  logic [8:0]       angle;

  // Double-dabble register: [20:9] BCD digits, [8:0] binary being shifted out.
  logic [20:0]      sh_q, sh_adj, sh_next;
  logic [3:0]       conv_cnt_q;
  logic [POS_W-1:0] pos_lat_q;
  logic [8:0]       deg_lat_q;

  logic [POS_W-1:0] pos_q;
  logic [8:0]       deg_q;
  logic [3:0]       hund_q, tens_q, ones_q;

  assign accept = (cand_q != acc_q) && (cnt_q == 8'(STABLE_CYC));

  always_comb begin
    acc_bin = '0;
    for (int i = 0; i < int'(POS_W); i++) begin
      acc_bin[i] = ^(acc_q >> i);
    end
  end

  assign angle = 9'(({9'd0, acc_bin} * ProdW'(360)) >> POS_W);

  always_comb begin
    sh_adj = sh_q;
    for (int k = 0; k < 3; k++) begin
      if (sh_q[9+4*k +: 4] >= 4'd5) begin
        sh_adj[9+4*k +: 4] = sh_q[9+4*k +: 4] + 4'd3;
      end
    end
    sh_next = {sh_adj[19:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    valid   = (state_q == StDone);
    busy    = (state_q != StIdle);
    unique case (state_q)
      StIdle:  if (pending_q) state_d = StLoad;
      StLoad:  state_d = StConv;
      StConv:  if (conv_cnt_q == 4'd8) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= gray_in;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= 8'd1;
      end else if ((cand_q != acc_q) && (cnt_q < 8'(STABLE_CYC))) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (accept) acc_q <= cand_q;
      // An acceptance coinciding with the IDLE hand-off is folded into that LOAD.
      if ((state_q == StIdle) && pending_q) begin
        pending_q <= 1'b0;
      end else if (accept) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      conv_cnt_q <= '0;
      pos_lat_q  <= '0;
      deg_lat_q  <= '0;
      pos_q      <= '0;
      deg_q      <= '0;
      hund_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
    end else begin
      if (state_q == StLoad) begin
        sh_q       <= {12'd0, angle};
        pos_lat_q  <= acc_bin;
        deg_lat_q  <= angle;
        conv_cnt_q <= '0;
      end else if (state_q == StConv) begin
        sh_q       <= sh_next;
        conv_cnt_q <= conv_cnt_q + 4'd1;
        // Results land on the edge into DONE so they are visible with valid.
        if (conv_cnt_q == 4'd8) begin
          pos_q  <= pos_lat_q;
          deg_q  <= deg_lat_q;
          hund_q <= sh_next[20:17];
          tens_q <= sh_next[16:13];
          ones_q <= sh_next[12:9];
        end
      end
    end
  end

  assign pos_bin  = pos_q;
  assign degrees  = deg_q;
  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

`ifdef GRAY_DIR_EN
  logic              dir_q, step_err_q;
  logic signed [7:0] turns_q;
  logic [POS_W-1:0]  delta;

  assign delta = pos_lat_q - pos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
      turns_q    <= '0;
    end else if ((state_q == StConv) && (conv_cnt_q == 4'd8)) begin
      if (delta == POS_W'(1)) begin
        dir_q      <= 1'b1;
        step_err_q <= 1'b0;
      end else if (delta == '1) begin
        dir_q      <= 1'b0;
        step_err_q <= 1'b0;
      end else if (delta == '0) begin
        step_err_q <= 1'b0;
      end else begin
        step_err_q <= 1'b1;
      end
      if ((pos_q == '1) && (pos_lat_q == '0) && (turns_q != 8'sd127)) begin
        turns_q <= turns_q + 8'sd1;
      end else if ((pos_q == '0) && (pos_lat_q == '1) && (turns_q != -8'sd128)) begin
        turns_q <= turns_q - 8'sd1;
      end
    end
  end

  assign dir      = dir_q;
  assign step_err = step_err_q;
  assign turns    = turns_q;
`endif

endmodule

// File: tb/tb_gray_angle_bcd_seq.sv
// Scoreboard bench for gray_angle_bcd_seq: a POS_W=3 and a POS_W=5 instance, directed
// Gray sequences, expected conversions queued at stimulus time and popped on valid.
module tb_gray_angle_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3, rst5;
  logic [2:0] gray3;
  logic [4:0] gray5;
  logic [2:0] pos3;
  logic [4:0] pos5;
  logic [8:0] deg3, deg5;
  logic [3:0] h3, t3, o3, h5, t5, o5;
  logic       valid3, busy3, valid5, busy5;
`ifdef GRAY_DIR_EN
  logic              dir3, serr3, dir5, serr5;
  logic signed [7:0] turns3, turns5;
`endif

  gray_angle_bcd_seq #(.POS_W(3), .STABLE_CYC(4)) u_dut3 (
    .clk(clk), .rst(rst3), .gray_in(gray3), .pos_bin(pos3), .degrees(deg3),
    .bcd_hund(h3), .bcd_tens(t3), .bcd_ones(o3), .valid(valid3), .busy(busy3)
`ifdef GRAY_DIR_EN
    , .dir(dir3), .step_err(serr3), .turns(turns3)
`endif
  );

  gray_angle_bcd_seq #(.POS_W(5), .STABLE_CYC(4)) u_dut5 (
    .clk(clk), .rst(rst5), .gray_in(gray5), .pos_bin(pos5), .degrees(deg5),
    .bcd_hund(h5), .bcd_tens(t5), .bcd_ones(o5), .valid(valid5), .busy(busy5)
`ifdef GRAY_DIR_EN
    , .dir(dir5), .step_err(serr5), .turns(turns5)
`endif
  );

  typedef struct {
    int pos; int deg; int h; int t; int o; int d; int se; int tr;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int p, input int dg, input int h, input int t, input int o,
                              input int d, input int se, input int tr);
    exp_t e;
    e.pos = p; e.deg = dg; e.h = h; e.t = t; e.o = o; e.d = d; e.se = se; e.tr = tr;
    return e;
  endfunction

  // Hand-computed: Gray step sequence, binary position, degrees, BCD digits.
  int g_tab [7] = '{1, 3, 2, 6, 7, 5, 4};
  int p_tab [7] = '{1, 2, 3, 4, 5, 6, 7};
  int d_tab [7] = '{45, 90, 135, 180, 225, 270, 315};
  int h_tab [7] = '{0, 0, 1, 1, 2, 2, 3};
  int t_tab [7] = '{4, 9, 3, 8, 2, 7, 1};
  int o_tab [7] = '{5, 0, 5, 0, 5, 0, 5};

  // Monitor for the POS_W=3 instance.
  initial begin
    int   cyc = 0;
    int   rise = 0;
    logic busy_p = 1'b0;
    logic valid_p = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy3 && !busy_p) rise = cyc;
      if (valid_p) chk("busy3_fall_after_valid", busy3, 0);
      if (valid3) begin
        chk("latency3", cyc - rise, 10);
        if (q3.size() == 0) begin
          chk("valid3_unexpected", valid3, 0);
        end else begin
          e = q3.pop_front();
          chk("pos3", pos3, e.pos);
          chk("deg3", deg3, e.deg);
          chk("hund3", h3, e.h);
          chk("tens3", t3, e.t);
          chk("ones3", o3, e.o);
        end
      end
      busy_p  = busy3;
      valid_p = valid3;
    end
  end

  // Monitor for the POS_W=5 instance.
  initial begin
    int   cyc = 0;
    int   rise = 0;
    logic busy_p = 1'b0;
    logic valid_p = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy5 && !busy_p) rise = cyc;
      if (valid_p) chk("busy5_fall_after_valid", busy5, 0);
      if (valid5) begin
        chk("latency5", cyc - rise, 10);
        if (q5.size() == 0) begin
          chk("valid5_unexpected", valid5, 0);
        end else begin
          e = q5.pop_front();
          chk("pos5", pos5, e.pos);
          chk("deg5", deg5, e.deg);
          chk("hund5", h5, e.h);
          chk("tens5", t5, e.t);
          chk("ones5", o5, e.o);
`ifdef GRAY_DIR_EN
          chk("dir5", dir5, e.d);
          chk("step_err5", serr5, e.se);
          chk("turns5", turns5, e.tr);
`endif
        end
      end
      busy_p  = busy5;
      valid_p = valid5;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_busy(input int sel, input string name);
    int n = 0;
    while (((sel == 3) ? !busy3 : !busy5) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, (sel == 3) ? int'(busy3) : int'(busy5), 1);
  endtask

  initial begin
    int n;
    rst3  = 1'b1;
    rst5  = 1'b1;
    gray3 = '0;
    gray5 = '0;
    repeat (3) @(negedge clk);
    rst3 = 1'b0;
    rst5 = 1'b0;

    // T1: idle input after reset, nothing converts.
    repeat (20) @(negedge clk);
    chk("t1_pos", pos3, 0);
    chk("t1_deg", deg3, 0);
    chk("t1_hund", h3, 0);
    chk("t1_tens", t3, 0);
    chk("t1_ones", o3, 0);
    chk("t1_busy3", busy3, 0);
    chk("t1_busy5", busy5, 0);

    // T2: full revolution, then wrap back to 0.
    for (int i = 0; i < 7; i++) begin
      gray3 = 3'(g_tab[i]);
      q3.push_back(mk(p_tab[i], d_tab[i], h_tab[i], t_tab[i], o_tab[i], 0, 0, 0));
      repeat (30) @(negedge clk);
    end
    gray3 = 3'b000;
    q3.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (30) @(negedge clk);

    // T4: short glitch is rejected, a held code is accepted once.
    gray3 = 3'b001;
    repeat (3) @(negedge clk);
    gray3 = 3'b000;
    repeat (30) @(negedge clk);
    chk("t4_glitch_busy", busy3, 0);
    gray3 = 3'b001;
    q3.push_back(mk(1, 45, 0, 4, 5, 0, 0, 0));
    repeat (30) @(negedge clk);

    // T5: new code accepted mid-conversion, reloads at DONE+2.
    gray3 = 3'b011;
    q3.push_back(mk(2, 90, 0, 9, 0, 0, 0, 0));
    wait_busy(3, "t5_busy_rise");
    repeat (2) @(negedge clk);
    gray3 = 3'b110;
    q3.push_back(mk(4, 180, 1, 8, 0, 0, 0, 0));
    n = 0;
    while (!valid3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_first_valid", valid3, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy3 && n < 10);
    chk("t5_reload_gap", n, 2);
    repeat (30) @(negedge clk);

    // T6: POS_W=5 non-exact angle, wrap, missed step, then reset mid-conversion.
    gray5 = 5'b10000;
    q5.push_back(mk(31, 348, 3, 4, 8, 0, 0, -1));
    repeat (30) @(negedge clk);
    gray5 = 5'b00000;
    q5.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    repeat (30) @(negedge clk);
    gray5 = 5'b00011;
    q5.push_back(mk(2, 22, 0, 2, 2, 1, 1, 0));
    repeat (30) @(negedge clk);

    gray5 = 5'b01100;
    wait_busy(5, "t6_busy_rise");
    repeat (3) @(negedge clk);
    rst5  = 1'b1;
    gray5 = 5'b00000;
    @(negedge clk);
    rst5 = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_rst_pos", pos5, 0);
    chk("t6_rst_deg", deg5, 0);
    chk("t6_rst_hund", h5, 0);
    chk("t6_rst_tens", t5, 0);
    chk("t6_rst_ones", o5, 0);
    chk("t6_rst_busy", busy5, 0);
`ifdef GRAY_DIR_EN
    chk("t6_rst_dir", dir5, 0);
    chk("t6_rst_step_err", serr5, 0);
    chk("t6_rst_turns", turns5, 0);
`endif

    chk("q3_drained", q3.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
